// File: rtl/fpu_cmp_pkg.sv
// Shared types, constants and IEEE-754 single-precision classification helpers
// for the FPU compare responder.
package fpu_cmp_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CAPT = 3'd1,
    S1   = 3'd2,
    S2   = 3'd3,
    DONE = 3'd4
  } cmp_state_t;

  // Codes 6 and 7 are illegal and have no enumerator.
  typedef enum logic [2:0] {
    EQ = 3'd0,
    NE = 3'd1,
    GT = 3'd2,
    GE = 3'd3,
    LT = 3'd4,
    LE = 3'd5
  } cmp_op_t;

  localparam logic [7:0]  FP_EXP_ALL1 = 8'hFF;
  localparam int unsigned CMP_OP_BIT  = 3;

  typedef struct packed {
    logic        nan;
    logic        snan;
    logic        zero;
    logic        sign;
    logic [30:0] mag;
  } cls_t;

  function automatic logic is_nan(input logic [31:0] v);
    return (v[30:23] == FP_EXP_ALL1) && (v[22:0] != '0);
  endfunction

  // A NaN with a clear quiet bit signals.
  function automatic logic is_snan(input logic [31:0] v);
    return is_nan(v) && !v[22];
  endfunction

  function automatic logic is_zero(input logic [31:0] v);
    return v[30:0] == '0;
  endfunction

endpackage

// File: rtl/fpu_cmp_responder_if.sv
// Decode/execute/flush handshake between the FPU driver and the compare responder.
interface fpu_cmp_responder_if #(
  parameter int unsigned OP_WIDTH = 8
);
  logic                flush;
  logic                decode;
  logic                execute;
  logic [OP_WIDTH-1:0] fpuOp;
  logic [31:0]         opA;
  logic [31:0]         opB;
  logic                compare;
  logic                validcompare;
  logic                cmp_inv;
  logic                busy;

  modport master (
    output flush, decode, execute, fpuOp, opA, opB,
    input  compare, validcompare, cmp_inv, busy
  );

  modport slave (
    input  flush, decode, execute, fpuOp, opA, opB,
    output compare, validcompare, cmp_inv, busy
  );
endinterface

// File: rtl/fpu_cmp_classify.sv
// Combinational per-operand classifier: NaN, signalling NaN, zero, sign, magnitude.
module fpu_cmp_classify
  import fpu_cmp_pkg::*;
(
  input  logic [31:0] op,
  output cls_t        cls
);

  // Pure decode of the operand fields.
  always_comb begin
    cls      = '0;
    cls.nan  = is_nan(op);
    cls.snan = is_snan(op);
    cls.zero = is_zero(op);
    cls.sign = op[31];
    cls.mag  = op[30:0];
  end

endmodule

// File: rtl/fpu_cmp_responder.sv
// Compare side of the FPU op handshake: captures operands on decode, classifies
// in S1, compares in S2, and holds the result until flush.
module fpu_cmp_responder
  import fpu_cmp_pkg::*;
#(
  parameter int unsigned OP_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  fpu_cmp_responder_if.slave bus
);

  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("fpu_cmp_responder: only DATA_WIDTH=32 is supported");
  end
  if (OP_WIDTH <= CMP_OP_BIT) begin : g_bad_op_width
    $error("fpu_cmp_responder: OP_WIDTH too narrow for the compare bit");
  end

  cmp_state_t  state, state_n;
  logic        cap_en;
  logic [31:0] a_q, b_q;
  cmp_op_t     op_q;
  cls_t        cls_a, cls_b, cls_a_q, cls_b_q;
  logic        res, inv;
  logic        compare_q, valid_q, inv_q;
  logic        is_cmp_op;
  logic        unused_op_bits;

  // Only bit 3 and the low op field matter to this responder.
  assign unused_op_bits = ^bus.fpuOp;
  assign is_cmp_op      = bus.fpuOp[CMP_OP_BIT];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and capture enable; flush overrides decode/execute everywhere.
  always_comb begin
    state_n = state;
    cap_en  = 1'b0;
    if (bus.flush) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: if (bus.decode && is_cmp_op) begin
          state_n = CAPT;
          cap_en  = 1'b1;
        end
        // Execute wins over a simultaneous decode so the previously latched op runs.
        CAPT: begin
          if (bus.execute)                    state_n = S1;
          else if (bus.decode && is_cmp_op)   cap_en  = 1'b1;
        end
        S1:      state_n = S2;
        S2:      state_n = DONE;
        DONE:    state_n = DONE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Operand/op capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= EQ;
    end else if (cap_en) begin
      a_q  <= bus.opA;
      b_q  <= bus.opB;
      op_q <= cmp_op_t'(bus.fpuOp[2:0]);
    end
  end

  fpu_cmp_classify u_cls_a (.op(a_q), .cls(cls_a));
  fpu_cmp_classify u_cls_b (.op(b_q), .cls(cls_b));

  // Classification is registered while in S1.
  always_ff @(posedge clk) begin
    if (rst) begin
      cls_a_q <= '0;
      cls_b_q <= '0;
    end else if (state == S1) begin
      cls_a_q <= cls_a;
      cls_b_q <= cls_b;
    end
  end

  // Compare evaluation from the registered classification.
  always_comb begin
    logic any_nan, any_snan, eq, lt, gt;
    any_nan  = cls_a_q.nan  || cls_b_q.nan;
    any_snan = cls_a_q.snan || cls_b_q.snan;
    eq = (cls_a_q.zero && cls_b_q.zero) ||
         ((cls_a_q.sign == cls_b_q.sign) && (cls_a_q.mag == cls_b_q.mag));
    if (eq)                              lt = 1'b0;
    else if (cls_a_q.sign != cls_b_q.sign) lt = cls_a_q.sign;
    else if (cls_a_q.sign)               lt = cls_a_q.mag > cls_b_q.mag;
    else                                 lt = cls_a_q.mag < cls_b_q.mag;
    gt  = !eq && !lt;
    res = 1'b0;
    inv = any_snan || any_nan;
    case (op_q)
      EQ: begin res = !any_nan && eq;         inv = any_snan; end
      NE: begin res = any_nan || !eq;         inv = any_snan; end
      GT: res = !any_nan && gt;
      GE: res = !any_nan && (gt || eq);
      LT: res = !any_nan && lt;
      LE: res = !any_nan && (lt || eq);
      default: begin res = 1'b0; inv = 1'b1; end
    endcase
  end

  // Result registers: loaded leaving S2, held in DONE, cleared by flush.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      compare_q <= 1'b0;
      valid_q   <= 1'b0;
      inv_q     <= 1'b0;
    end else if (state == S2) begin
      compare_q <= res;
      valid_q   <= 1'b1;
      inv_q     <= inv;
    end
  end

  assign bus.compare      = compare_q;
  assign bus.validcompare = valid_q;
  assign bus.cmp_inv      = inv_q;
  assign bus.busy         = (state != IDLE);

endmodule
